// File: rtl/adder_16.sv
// Registered 16-bit adder built from four 4-bit CLA groups and a group-level
// lookahead unit; sum, carry-out and signed overflow appear one cycle later.
module adder_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);

    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    logic [15:0] sum_d, sum_q;
    logic        cout_d, cout_q;
    logic        ovf_d, ovf_q;
    logic        vld_q;

    assign g = x & y;
    assign p = x ^ y;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;

        assign gg[k] = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k] = &p[B+3:B];

        // In-group carries in flat lookahead form from the group carry-in
        assign c[B]   = gc[k];
        assign c[B+1] = g[B]
                      | (p[B] & gc[k]);
        assign c[B+2] = g[B+1]
                      | (p[B+1] & g[B])
                      | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2]
                      | (p[B+2] & g[B+1])
                      | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    assign gc[0] = cin;
    assign gc[1] = gg[0]
                 | (gp[0] & cin);
    assign gc[2] = gg[1]
                 | (gp[1] & gg[0])
                 | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2]
                 | (gp[2] & gg[1])
                 | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3]
                 | (gp[3] & gg[2])
                 | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    assign c[16] = gc[4];

    assign sum_d  = p ^ c[15:0];
    assign cout_d = c[16];
    assign ovf_d  = c[15] ^ c[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 16'h0000;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = vld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_16.sv
// Scoreboard bench for adder_16: directed plan vectors with literal results,
// then a random sweep checked against a behavioural 17-bit add.
module tb_adder_16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    adder_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // {sum, cout, ovf}
    logic [17:0] sb_q[$];

    logic [15:0] hs;
    logic        hc;
    logic        ho;
    logic        mon_v;
    logic        mon_r;
    logic [17:0] mon_e;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic        ci);
        logic [16:0] r;
        logic        v;
        r = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
        v = (a[15] == b[15]) && (r[15] != a[15]);
        return {r[15:0], r[16], v};
    endfunction

    task automatic put(input logic [15:0] a, input logic [15:0] b,
                       input logic ci);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; x = a; y = b; cin = ci;
        sb_q.push_back(model(a, b, ci));
    endtask

    task automatic put_exp(input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic [15:0] es,
                           input logic ec, input logic eo);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; x = a; y = b; cin = ci;
        sb_q.push_back({es, ec, eo});
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; x = 'x; y = 'x; cin = 1'bx;
    endtask

    task automatic do_rst(input logic v, input logic [15:0] a,
                          input logic [15:0] b);
        @(negedge clk);
        rst = 1'b1; in_valid = v; x = a; y = b; cin = 1'b0;
    endtask

    // Monitor: track what the output register should hold after every edge
    initial begin
        hs = 16'h0000; hc = 1'b0; ho = 1'b0;
    end

    always @(posedge clk) begin
        mon_v = in_valid && !rst;
        mon_r = rst;
        #1;
        if (mon_r) begin
            hs = 16'h0000; hc = 1'b0; ho = 1'b0;
        end else if (mon_v) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                hs = mon_e[17:2];
                hc = mon_e[1];
                ho = mon_e[0];
            end
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, mon_v});
        check("sum", {16'd0, sum}, {16'd0, hs});
        check("cout", {31'd0, cout}, {31'd0, hc});
        check("ovf", {31'd0, ovf}, {31'd0, ho});
    end

    initial begin
        int nv;
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0;
        do_rst(1'b0, 16'h0000, 16'h0000);
        do_rst(1'b0, 16'h0000, 16'h0000);

        put_exp(16'h1111, 16'h4444, 1'b0, 16'h5555, 1'b0, 1'b0);
        idle();
        put_exp(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        put_exp(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        put_exp(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        put_exp(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        idle();
        put_exp(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        put_exp(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        idle();
        idle();
        put_exp(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        do_rst(1'b1, 16'h1234, 16'h1111);
        idle();

        nv = 0;
        while (nv < 10000) begin
            if ($urandom_range(0, 9) == 0) begin
                idle();
            end else begin
                put(16'($urandom), 16'($urandom), 1'($urandom));
                nv++;
            end
        end
        idle();
        idle();
        @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
